// File: rtl/upg_word_loader.sv
// upg_word_loader
//   Frames the UART byte stream used to program the instruction ROM. The frame
//   is a 16-bit little-endian word count followed by that many 32-bit
//   little-endian words. Each complete word is written to the ROM through a
//   single-cycle write pulse. The loader stops when the image is complete,
//   when the count is bad, or when the sender stalls for too long.
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   rx_valid_i  1-cycle strobe, rx_data_i holds a new byte
//   rx_data_i   received byte
//   upg_wen_o   ROM write enable, one pulse per word
//   upg_adr_o   ROM word address, 0-based
//   upg_dat_o   ROM write data
//   upg_done_o  sticky, full image written
//   upg_err_o   sticky, bad count or inter-byte timeout
//   busy_o      frame in progress
module upg_word_loader #(
    parameter int ADDR_W         = 14,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              upg_err_o,
    output logic              busy_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // S_LAST spans the final write pulse so that done rises one cycle later.
    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_LAST,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [15:0]       count;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] word_idx;
    logic [TW-1:0]     timer;
    logic [23:0]       shift;

    logic [15:0]       full_count;
    logic              timeout;
    logic              last_word;
    logic              word_write;
    logic              timing;

    always_comb begin
        full_count = {rx_data_i, count[7:0]};
        timing     = (state == S_LEN1) || (state == S_DATA);
        timeout    = timing && !rx_valid_i && (timer == TW'(TIMEOUT_CYCLES - 1));
        last_word  = (32'(word_idx) + 32'd1) == 32'(count);
        word_write = (state == S_DATA) && rx_valid_i && (byte_idx == 2'd3);
        state_nxt  = state;
        case (state)
            S_LEN0: begin
                if (rx_valid_i) state_nxt = S_LEN1;
            end
            S_LEN1: begin
                if (rx_valid_i) begin
                    if (full_count == 16'd0)
                        state_nxt = S_DONE;
                    else if (32'(full_count) > (32'd1 << ADDR_W))
                        state_nxt = S_ERR;
                    else
                        state_nxt = S_DATA;
                end else if (timeout) begin
                    state_nxt = S_ERR;
                end
            end
            S_DATA: begin
                if (word_write && last_word)
                    state_nxt = S_LAST;
                else if (timeout)
                    state_nxt = S_ERR;
            end
            S_LAST:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_LEN0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_LEN0;
            count     <= '0;
            byte_idx  <= '0;
            word_idx  <= '0;
            timer     <= '0;
            shift     <= '0;
            upg_wen_o <= 1'b0;
            upg_adr_o <= '0;
            upg_dat_o <= '0;
        end else begin
            state     <= state_nxt;
            upg_wen_o <= word_write;

            if (timing && !rx_valid_i)
                timer <= timer + 1'b1;
            else
                timer <= '0;

            if ((state == S_LEN0) && rx_valid_i)
                count[7:0] <= rx_data_i;
            if ((state == S_LEN1) && rx_valid_i)
                count[15:8] <= rx_data_i;

            if ((state == S_DATA) && rx_valid_i) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: shift[7:0]   <= rx_data_i;
                    2'd1: shift[15:8]  <= rx_data_i;
                    2'd2: shift[23:16] <= rx_data_i;
                    default: begin
                        // Address is captured before the index advances, so the
                        // pulse carries the index of the word just completed.
                        upg_dat_o <= {rx_data_i, shift};
                        upg_adr_o <= word_idx;
                        word_idx  <= word_idx + 1'b1;
                    end
                endcase
            end
        end
    end

    assign upg_done_o = (state == S_DONE);
    assign upg_err_o  = (state == S_ERR);
    assign busy_o     = (state == S_LEN1) || (state == S_DATA) || (state == S_LAST);

endmodule

// File: tb/tb_upg_word_loader.sv
module tb_upg_word_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx2_valid = 1'b0;
    logic [7:0]  rx2_data = '0;

    logic        wen, done, err, busy;
    logic [13:0] adr;
    logic [31:0] dat;
    logic        wen2, done2, err2, busy2;
    logic [1:0]  adr2;
    logic [31:0] dat2;

    int total = 0;
    int bad = 0;

    logic [15:0] adr_q[$];
    logic [31:0] dat_q[$];
    logic [15:0] adr2_q[$];
    logic [31:0] dat2_q[$];
    int          dbl = 0;
    logic        prev_wen = 1'b0;

    always #5 clk = ~clk;

    upg_word_loader #(.ADDR_W(14), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .upg_wen_o(wen), .upg_adr_o(adr), .upg_dat_o(dat),
        .upg_done_o(done), .upg_err_o(err), .busy_o(busy)
    );

    upg_word_loader #(.ADDR_W(2), .TIMEOUT_CYCLES(1000)) dut2 (
        .clk(clk), .rst(rst), .rx_valid_i(rx2_valid), .rx_data_i(rx2_data),
        .upg_wen_o(wen2), .upg_adr_o(adr2), .upg_dat_o(dat2),
        .upg_done_o(done2), .upg_err_o(err2), .busy_o(busy2)
    );

    // Write-pulse logger, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (wen) begin
            adr_q.push_back(16'(adr));
            dat_q.push_back(dat);
            if (prev_wen) dbl++;
        end
        prev_wen = wen;
        if (wen2) begin
            adr2_q.push_back(16'(adr2));
            dat2_q.push_back(dat2);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int sel, input logic [7:0] b);
        if (sel == 0) begin rx_valid = 1'b1; rx_data = b; end
        else          begin rx2_valid = 1'b1; rx2_data = b; end
        @(negedge clk);
        rx_valid = 1'b0;
        rx2_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        adr_q.delete(); dat_q.delete(); adr2_q.delete(); dat2_q.delete();
        dbl = 0;
    endtask

    task automatic send_frame1();
        logic [7:0] b[10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                              8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 10; i++) send(0, b[i]);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({wen, done, err, busy} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {wen, done, err, busy});
        end
        total++;
        if (adr !== 14'd0 || dat !== 32'd0) begin
            bad++; $display("FAIL reset_bus: got adr=%h dat=%h want 0/0", adr, dat);
        end
        total++;
        if ({wen2, done2, err2, busy2} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags2: got %b want 0000", {wen2, done2, err2, busy2});
        end
    endtask

    task automatic check_frame1(input string tag);
        total++;
        if (adr_q.size() != 2) begin
            bad++; $display("FAIL %s_nwrites: got %0d want 2", tag, adr_q.size());
        end else begin
            total++;
            if (adr_q[0] !== 16'd0 || dat_q[0] !== 32'h12345678) begin
                bad++; $display("FAIL %s_w0: got adr=%h dat=%h want 0000/12345678", tag, adr_q[0], dat_q[0]);
            end
            total++;
            if (adr_q[1] !== 16'd1 || dat_q[1] !== 32'hDEADBEEF) begin
                bad++; $display("FAIL %s_w1: got adr=%h dat=%h want 0001/deadbeef", tag, adr_q[1], dat_q[1]);
            end
        end
    endtask

    task automatic test_two_words();
        do_reset();
        send_frame1();
        total++;
        if (wen !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL last_pulse: got wen=%b done=%b busy=%b want 1/0/1", wen, done, busy);
        end
        idle(1);
        total++;
        if (wen !== 1'b0 || done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL done_after_pulse: got wen=%b done=%b err=%b busy=%b want 0/1/0/0", wen, done, err, busy);
        end
        total++;
        if (adr !== 14'd1 || dat !== 32'hDEADBEEF) begin
            bad++; $display("FAIL hold_bus: got adr=%h dat=%h want 0001/deadbeef", adr, dat);
        end
        idle(2);
        check_frame1("t1");
    endtask

    task automatic test_zero_count();
        do_reset();
        send(0, 8'h00);
        send(0, 8'h00);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            bad++; $display("FAIL zero_done: got done=%b busy=%b err=%b want 1/0/0", done, busy, err);
        end
        send(0, 8'h55);
        idle(3);
        total++;
        if (adr_q.size() != 0) begin
            bad++; $display("FAIL zero_nowen: got %0d writes want 0", adr_q.size());
        end
    endtask

    task automatic test_bad_count();
        do_reset();
        send(0, 8'h01);
        send(0, 8'h40);
        total++;
        if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL badcnt_err: got err=%b done=%b busy=%b want 1/0/0", err, done, busy);
        end
        for (int i = 0; i < 4; i++) send(0, 8'(i + 1));
        idle(2);
        total++;
        if (adr_q.size() != 0 || err !== 1'b1) begin
            bad++; $display("FAIL badcnt_nowen: got writes=%0d err=%b want 0/1", adr_q.size(), err);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send(0, 8'h01);
        send(0, 8'h00);
        send(0, 8'hAA);
        send(0, 8'hBB);
        idle(15);
        total++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL timeout_early: got err=%b busy=%b want 0/1", err, busy);
        end
        idle(1);
        total++;
        if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL timeout_err: got err=%b busy=%b done=%b want 1/0/0", err, busy, done);
        end
        total++;
        if (adr_q.size() != 0) begin
            bad++; $display("FAIL timeout_nowen: got %0d writes want 0", adr_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  b[14] = '{8'h03, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01,
                               8'h08, 8'h07, 8'h06, 8'h05, 8'h0C, 8'h0B, 8'h0A, 8'h09};
        logic [31:0] exp[3] = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
        do_reset();
        for (int i = 0; i < 14; i++) send(0, b[i]);
        idle(3);
        total++;
        if (adr_q.size() != 3) begin
            bad++; $display("FAIL b2b_nwrites: got %0d want 3", adr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (adr_q[i] !== 16'(i) || dat_q[i] !== exp[i]) begin
                    bad++; $display("FAIL b2b_w%0d: got adr=%h dat=%h want %h/%h", i, adr_q[i], dat_q[i], 16'(i), exp[i]);
                end
            end
        end
        total++;
        if (dbl != 0) begin
            bad++; $display("FAIL b2b_single_pulse: got %0d back-to-back pulses want 0", dbl);
        end
        total++;
        if (done !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL b2b_done: got done=%b err=%b want 1/0", done, err);
        end
    endtask

    task automatic test_midframe_reset();
        do_reset();
        send(0, 8'h02); send(0, 8'h00); send(0, 8'h78); send(0, 8'h56); send(0, 8'h34);
        // Byte presented together with reset must be discarded.
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h05;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({wen, done, err, busy} !== 4'b0000 || adr !== 14'd0) begin
            bad++; $display("FAIL abort_state: got flags=%b adr=%h want 0000/0000", {wen, done, err, busy}, adr);
        end
        adr_q.delete(); dat_q.delete();
        send_frame1();
        idle(2);
        check_frame1("t6");
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL t6_done: got %b want 1", done);
        end
        for (int i = 0; i < 5; i++) send(0, 8'hE0 + 8'(i));
        idle(2);
        total++;
        if (adr_q.size() != 2 || done !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL t6_ignore: got writes=%0d done=%b err=%b want 2/1/0", adr_q.size(), done, err);
        end
    endtask

    task automatic test_addr_boundary();
        logic [31:0] e;
        do_reset();
        send(1, 8'h04);
        send(1, 8'h00);
        for (int k = 1; k <= 4; k++)
            for (int j = 0; j < 4; j++) send(1, 8'(k * 16 + j));
        idle(2);
        total++;
        if (adr2_q.size() != 4) begin
            bad++; $display("FAIL full_nwrites: got %0d want 4", adr2_q.size());
        end else begin
            for (int k = 1; k <= 4; k++) begin
                e = {8'(k * 16 + 3), 8'(k * 16 + 2), 8'(k * 16 + 1), 8'(k * 16)};
                total++;
                if (adr2_q[k-1] !== 16'(k - 1) || dat2_q[k-1] !== e) begin
                    bad++; $display("FAIL full_w%0d: got adr=%h dat=%h want %h/%h", k - 1, adr2_q[k-1], dat2_q[k-1], 16'(k - 1), e);
                end
            end
        end
        total++;
        if (done2 !== 1'b1 || err2 !== 1'b0) begin
            bad++; $display("FAIL full_done: got done=%b err=%b want 1/0", done2, err2);
        end
        do_reset();
        send(1, 8'h05);
        send(1, 8'h00);
        total++;
        if (err2 !== 1'b1 || done2 !== 1'b0) begin
            bad++; $display("FAIL over_err: got err=%b done=%b want 1/0", err2, done2);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_two_words();
        test_zero_count();
        test_bad_count();
        test_timeout();
        test_back_to_back();
        test_midframe_reset();
        test_addr_boundary();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
